// File: rtl/os_tile_scheduler_if.sv
// Token stream carrying one A column slice and one B row slice per beat.
// The producer side drives valid/data; the scheduler answers with ready.
interface os_tile_scheduler_if #(
    parameter int ROWS     = 64,
    parameter int COLS     = 64,
    parameter int IP_WIDTH = 8
);
    logic                     tok_valid;
    logic                     tok_ready;
    logic [ROWS*IP_WIDTH-1:0] tok_a;
    logic [COLS*IP_WIDTH-1:0] tok_b;

    modport master (output tok_valid, output tok_a, output tok_b, input tok_ready);
    modport slave  (input tok_valid, input tok_a, input tok_b, output tok_ready);
endinterface

// File: rtl/os_tile_scheduler.sv
// Output-stationary tile scheduler: streams K tokens into a systolic array,
// waits for the array to drain, then presents the finished tile.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; k_len captured on acceptance
// S_FEED   | accepting tokens, each drives the array one cycle later
// S_DRAIN  | no tokens; wait for done or the drain timeout
// S_RESULT | res_valid high until res_ready; err reports k_len=0/timeout
module os_tile_scheduler #(
    parameter int ROWS        = 64,
    parameter int COLS        = 64,
    parameter int IP_WIDTH    = 8,
    parameter int K_WIDTH     = 16,
    parameter int DRAIN_SLACK = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [K_WIDTH-1:0]       i_k_len,
    os_tile_scheduler_if.slave       tok,
    output logic                     o_arr_en,
    output logic                     o_arr_clr,
    output logic [ROWS*IP_WIDTH-1:0] o_arr_input_matrix,
    output logic [COLS*IP_WIDTH-1:0] o_arr_weight_matrix,
    input  logic                     i_arr_compute_done,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic                     o_busy,
    output logic                     o_err,
    output logic [31:0]              o_tile_cycles
);

    // The drain timer is a down-counter loaded on DRAIN entry so that the
    // timeout fires after exactly DRAIN_LIMIT cycles spent in DRAIN.
    localparam int DRAIN_LIMIT = ROWS + COLS + DRAIN_SLACK;
    localparam int DW          = $clog2(DRAIN_LIMIT + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_LIMIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_RESULT} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_err;
    logic                     w_err_nxt;
    logic [K_WIDTH-1:0]       r_k_len;
    logic [K_WIDTH-1:0]       r_tok_cnt;
    logic [DW-1:0]            r_drain_cnt;
    logic [31:0]              r_tile_cycles;
    logic                     r_arr_en;
    logic                     r_arr_clr;
    logic [ROWS*IP_WIDTH-1:0] r_arr_in;
    logic [COLS*IP_WIDTH-1:0] r_arr_wt;

    logic w_start_ok;
    logic w_accept;
    logic w_last_tok;
    logic w_drain_tc;
    logic w_count_en;

    assign w_start_ok = (r_state == S_IDLE) && i_start;
    assign w_accept   = (r_state == S_FEED) && tok.tok_valid;
    assign w_last_tok = w_accept && (r_tok_cnt == (r_k_len - K_WIDTH'(1)));
    assign w_drain_tc = (r_drain_cnt == '0);
    // The cycle that hands over to RESULT is not counted, so a tile whose
    // done arrives after D drain cycles reports k_len + D.
    assign w_count_en = (r_state == S_FEED) ||
                        ((r_state == S_DRAIN) && (w_state_nxt == S_DRAIN));

    // State and error flag register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and error decision.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_k_len == '0) begin
                        w_state_nxt = S_RESULT;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_FEED;
                    end
                end
            end
            S_FEED: begin
                if (w_last_tok) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_arr_compute_done) begin
                    w_state_nxt = S_RESULT;
                    w_err_nxt   = 1'b0;
                end else if (w_drain_tc) begin
                    w_state_nxt = S_RESULT;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RESULT: begin
                if (i_res_ready) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_err_nxt   = 1'b0;
            end
        endcase
    end

    // Array drive, token/drain counters and the tile cycle counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arr_en      <= 1'b0;
            r_arr_clr     <= 1'b0;
            r_arr_in      <= '0;
            r_arr_wt      <= '0;
            r_k_len       <= '0;
            r_tok_cnt     <= '0;
            r_drain_cnt   <= '0;
            r_tile_cycles <= '0;
        end else begin
            r_arr_en  <= w_accept;
            r_arr_clr <= w_accept && (r_tok_cnt == '0);
            r_arr_in  <= w_accept ? tok.tok_a : '0;
            r_arr_wt  <= w_accept ? tok.tok_b : '0;

            if (w_start_ok) begin
                r_k_len   <= i_k_len;
                r_tok_cnt <= '0;
            end else if (w_accept) begin
                r_tok_cnt <= r_tok_cnt + K_WIDTH'(1);
            end

            if (w_last_tok) begin
                r_drain_cnt <= DRAIN_LOAD;
            end else if ((r_state == S_DRAIN) && !w_drain_tc) begin
                r_drain_cnt <= r_drain_cnt - DW'(1);
            end

            if (w_start_ok) begin
                r_tile_cycles <= '0;
            end else if (w_count_en && (r_tile_cycles != 32'hFFFF_FFFF)) begin
                r_tile_cycles <= r_tile_cycles + 32'd1;
            end
        end
    end

    assign tok.tok_ready         = (r_state == S_FEED);
    assign o_arr_en              = r_arr_en;
    assign o_arr_clr             = r_arr_clr;
    assign o_arr_input_matrix    = r_arr_in;
    assign o_arr_weight_matrix   = r_arr_wt;
    assign o_res_valid           = (r_state == S_RESULT);
    assign o_busy                = (r_state != S_IDLE);
    assign o_err                 = r_err;
    assign o_tile_cycles         = r_tile_cycles;

endmodule

// File: tb/tb_os_tile_scheduler.sv
// Directed bench for os_tile_scheduler: a default-size instance for the
// functional scenarios and a 4x4 / slack 2 instance for the drain timeout.
module tb_os_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] k_len = '0;
    logic        done = 1'b0;
    logic        res_ready = 1'b0;

    logic         b_arr_en, b_arr_clr, b_res_valid, b_busy, b_err;
    logic [511:0] b_in, b_wt;
    logic [31:0]  b_tile;

    logic        s_start = 1'b0;
    logic [15:0] s_k_len = '0;
    logic        s_done = 1'b0;
    logic        s_res_ready = 1'b0;
    logic        s_arr_en, s_arr_clr, s_res_valid, s_busy, s_err;
    logic [31:0] s_in, s_wt;
    logic [31:0] s_tile;

    int n_err = 0;
    int n_chk = 0;

    os_tile_scheduler_if #(.ROWS(64), .COLS(64), .IP_WIDTH(8)) tok_big ();
    os_tile_scheduler_if #(.ROWS(4),  .COLS(4),  .IP_WIDTH(8)) tok_sml ();

    os_tile_scheduler u_big (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len),
        .tok(tok_big),
        .o_arr_en(b_arr_en), .o_arr_clr(b_arr_clr),
        .o_arr_input_matrix(b_in), .o_arr_weight_matrix(b_wt),
        .i_arr_compute_done(done), .o_res_valid(b_res_valid),
        .i_res_ready(res_ready), .o_busy(b_busy), .o_err(b_err),
        .o_tile_cycles(b_tile)
    );

    os_tile_scheduler #(.ROWS(4), .COLS(4), .IP_WIDTH(8), .K_WIDTH(16), .DRAIN_SLACK(2)) u_sml (
        .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_k_len(s_k_len),
        .tok(tok_sml),
        .o_arr_en(s_arr_en), .o_arr_clr(s_arr_clr),
        .o_arr_input_matrix(s_in), .o_arr_weight_matrix(s_wt),
        .i_arr_compute_done(s_done), .o_res_valid(s_res_valid),
        .i_res_ready(s_res_ready), .o_busy(s_busy), .o_err(s_err),
        .o_tile_cycles(s_tile)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] fa(input int n);
        logic [31:0] w;
        w = 32'(n) + 32'h1000_0000;
        return {16{w}};
    endfunction

    function automatic logic [511:0] fb(input int n);
        logic [31:0] w;
        w = ~32'(n);
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_chk++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", b_busy); end
        n_chk++; if (b_arr_en !== 1'b0 || b_arr_clr !== 1'b0) begin n_err++; $display("FAIL reset_arr: got en=%0b clr=%0b want 0 0", b_arr_en, b_arr_clr); end
        n_chk++; if (b_in !== '0 || b_wt !== '0) begin n_err++; $display("FAIL reset_bus: got a=%0h b=%0h want 0", b_in, b_wt); end
        n_chk++; if (tok_big.tok_ready !== 1'b0 || b_res_valid !== 1'b0 || b_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got rdy=%0b rv=%0b err=%0b want 0 0 0", tok_big.tok_ready, b_res_valid, b_err); end
        n_chk++; if (b_tile !== 32'd0) begin n_err++; $display("FAIL reset_tile: got %0d want 0", b_tile); end
        // reset wins over a simultaneous start
        start = 1'b1; k_len = 16'd5;
        tick();
        n_chk++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL reset_prio_start: got busy=%0b want 0", b_busy); end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_full_tile();
        int en_cnt = 0;
        int clr_cnt = 0;
        start = 1'b1; k_len = 16'd128;
        tick();
        start = 1'b0;
        n_chk++; if (b_busy !== 1'b1 || tok_big.tok_ready !== 1'b1) begin n_err++; $display("FAIL full_feed_entry: got busy=%0b rdy=%0b want 1 1", b_busy, tok_big.tok_ready); end
        for (int i = 0; i < 128; i++) begin
            tok_big.tok_valid = 1'b1; tok_big.tok_a = fa(i); tok_big.tok_b = fb(i);
            tick();
            if (b_arr_en) en_cnt++;
            if (b_arr_clr) clr_cnt++;
            n_chk++; if (b_arr_clr !== (i == 0)) begin n_err++; $display("FAIL full_clr[%0d]: got %0b want %0b", i, b_arr_clr, (i == 0)); end
            n_chk++; if (b_in !== fa(i) || b_wt !== fb(i)) begin n_err++; $display("FAIL full_data[%0d]: got a=%0h want %0h", i, b_in, fa(i)); end
        end
        tok_big.tok_valid = 1'b0;
        n_chk++; if (tok_big.tok_ready !== 1'b0 || b_busy !== 1'b1) begin n_err++; $display("FAIL full_drain_entry: got rdy=%0b busy=%0b want 0 1", tok_big.tok_ready, b_busy); end
        for (int d = 0; d < 127; d++) begin
            tick();
            if (b_arr_en) en_cnt++;
        end
        n_chk++; if (b_res_valid !== 1'b0 || b_busy !== 1'b1) begin n_err++; $display("FAIL full_still_drain: got rv=%0b busy=%0b want 0 1", b_res_valid, b_busy); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_chk++; if (b_res_valid !== 1'b1 || b_err !== 1'b0) begin n_err++; $display("FAIL full_result: got rv=%0b err=%0b want 1 0", b_res_valid, b_err); end
        n_chk++; if (b_tile !== 32'd255) begin n_err++; $display("FAIL full_tile_cycles: got %0d want 255", b_tile); end
        n_chk++; if (en_cnt !== 128 || clr_cnt !== 1) begin n_err++; $display("FAIL full_pulses: got en=%0d clr=%0d want 128 1", en_cnt, clr_cnt); end
        n_chk++; if (b_in !== '0 || b_wt !== '0) begin n_err++; $display("FAIL full_bus_idle: got a=%0h want 0", b_in); end
        for (int w = 0; w < 3; w++) begin
            tick();
            n_chk++; if (b_res_valid !== 1'b1) begin n_err++; $display("FAIL full_hold[%0d]: got rv=%0b want 1", w, b_res_valid); end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_chk++; if (b_res_valid !== 1'b0 || b_busy !== 1'b0 || b_err !== 1'b0) begin n_err++; $display("FAIL full_release: got rv=%0b busy=%0b err=%0b want 0 0 0", b_res_valid, b_busy, b_err); end
        n_chk++; if (b_tile !== 32'd255) begin n_err++; $display("FAIL full_tile_held: got %0d want 255", b_tile); end
    endtask

    task automatic test_bubbles();
        logic [6:0] pat;
        int tokn = 0;
        pat = 7'b1011001;
        start = 1'b1; k_len = 16'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tok_big.tok_valid = pat[i];
            tok_big.tok_a = pat[i] ? fa(100 + tokn) : fa(999);
            tok_big.tok_b = pat[i] ? fb(100 + tokn) : fb(999);
            tick();
            n_chk++; if (b_arr_en !== pat[i]) begin n_err++; $display("FAIL bub_en[%0d]: got %0b want %0b", i, b_arr_en, pat[i]); end
            if (pat[i]) begin
                n_chk++; if (b_in !== fa(100 + tokn) || b_wt !== fb(100 + tokn)) begin n_err++; $display("FAIL bub_data[%0d]: got a=%0h want %0h", i, b_in, fa(100 + tokn)); end
                n_chk++; if (b_arr_clr !== (tokn == 0)) begin n_err++; $display("FAIL bub_clr[%0d]: got %0b want %0b", i, b_arr_clr, (tokn == 0)); end
                tokn++;
            end else begin
                n_chk++; if (b_in !== '0 || b_wt !== '0 || b_arr_clr !== 1'b0) begin n_err++; $display("FAIL bub_frozen[%0d]: got a=%0h clr=%0b want 0 0", i, b_in, b_arr_clr); end
            end
        end
        tok_big.tok_valid = 1'b0;
        n_chk++; if (tok_big.tok_ready !== 1'b0 || b_busy !== 1'b1) begin n_err++; $display("FAIL bub_drain_entry: got rdy=%0b busy=%0b want 0 1", tok_big.tok_ready, b_busy); end
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_chk++; if (b_res_valid !== 1'b1 || b_err !== 1'b0) begin n_err++; $display("FAIL bub_result: got rv=%0b err=%0b want 1 0", b_res_valid, b_err); end
        n_chk++; if (b_tile !== 32'd10) begin n_err++; $display("FAIL bub_tile_cycles: got %0d want 10", b_tile); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_zero_k();
        start = 1'b1; k_len = 16'd0;
        tick();
        start = 1'b0;
        n_chk++; if (b_res_valid !== 1'b1 || b_err !== 1'b1 || b_busy !== 1'b1) begin n_err++; $display("FAIL zk_result: got rv=%0b err=%0b busy=%0b want 1 1 1", b_res_valid, b_err, b_busy); end
        n_chk++; if (b_tile !== 32'd0) begin n_err++; $display("FAIL zk_tile: got %0d want 0", b_tile); end
        n_chk++; if (b_arr_en !== 1'b0 || tok_big.tok_ready !== 1'b0) begin n_err++; $display("FAIL zk_array: got en=%0b rdy=%0b want 0 0", b_arr_en, tok_big.tok_ready); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_chk++; if (b_err !== 1'b0 || b_busy !== 1'b0) begin n_err++; $display("FAIL zk_release: got err=%0b busy=%0b want 0 0", b_err, b_busy); end
    endtask

    task automatic test_timeout();
        s_start = 1'b1; s_k_len = 16'd2;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tok_sml.tok_valid = 1'b1; tok_sml.tok_a = 32'(i + 7); tok_sml.tok_b = 32'(i + 9);
            tick();
        end
        tok_sml.tok_valid = 1'b0;
        for (int t = 1; t < 10; t++) begin
            tick();
            n_chk++; if (s_busy !== 1'b1 || s_res_valid !== 1'b0) begin n_err++; $display("FAIL to_drain[%0d]: got busy=%0b rv=%0b want 1 0", t, s_busy, s_res_valid); end
        end
        tick();
        n_chk++; if (s_res_valid !== 1'b1 || s_err !== 1'b1) begin n_err++; $display("FAIL to_expire: got rv=%0b err=%0b want 1 1", s_res_valid, s_err); end
        s_res_ready = 1'b1;
        tick();
        s_res_ready = 1'b0;
        n_chk++; if (s_err !== 1'b0 || s_busy !== 1'b0) begin n_err++; $display("FAIL to_release: got err=%0b busy=%0b want 0 0", s_err, s_busy); end
    endtask

    task automatic test_reset_mid_feed();
        start = 1'b1; k_len = 16'd128;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tok_big.tok_valid = 1'b1; tok_big.tok_a = fa(i); tok_big.tok_b = fb(i);
            tick();
        end
        tok_big.tok_a = fa(50); tok_big.tok_b = fb(50);
        rst = 1'b1;
        tick();
        rst = 1'b0; tok_big.tok_valid = 1'b0;
        n_chk++; if (b_arr_en !== 1'b0 || b_arr_clr !== 1'b0 || b_in !== '0 || b_wt !== '0) begin n_err++; $display("FAIL rmf_array: got en=%0b clr=%0b a=%0h want 0", b_arr_en, b_arr_clr, b_in); end
        n_chk++; if (tok_big.tok_ready !== 1'b0 || b_res_valid !== 1'b0 || b_err !== 1'b0 || b_busy !== 1'b0) begin n_err++; $display("FAIL rmf_flags: got rdy=%0b rv=%0b err=%0b busy=%0b want 0", tok_big.tok_ready, b_res_valid, b_err, b_busy); end
        n_chk++; if (b_tile !== 32'd0) begin n_err++; $display("FAIL rmf_tile: got %0d want 0", b_tile); end
        start = 1'b1; k_len = 16'd8;
        tick();
        start = 1'b0;
        n_chk++; if (b_busy !== 1'b1 || tok_big.tok_ready !== 1'b1) begin n_err++; $display("FAIL rmf_restart: got busy=%0b rdy=%0b want 1 1", b_busy, tok_big.tok_ready); end
        for (int i = 0; i < 8; i++) begin
            tok_big.tok_valid = 1'b1; tok_big.tok_a = fa(200 + i); tok_big.tok_b = fb(200 + i);
            tick();
            n_chk++; if (b_arr_en !== 1'b1 || b_arr_clr !== (i == 0)) begin n_err++; $display("FAIL rmf_tok[%0d]: got en=%0b clr=%0b want 1 %0b", i, b_arr_en, b_arr_clr, (i == 0)); end
        end
        tok_big.tok_valid = 1'b0;
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_chk++; if (b_res_valid !== 1'b1 || b_err !== 1'b0 || b_tile !== 32'd10) begin n_err++; $display("FAIL rmf_result: got rv=%0b err=%0b tile=%0d want 1 0 10", b_res_valid, b_err, b_tile); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_ignored();
        int en_cnt = 0;
        start = 1'b1; k_len = 16'd4;
        tick();
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; k_len = 16'd0; done = 1'b1;
            tok_big.tok_valid = 1'b1; tok_big.tok_a = fa(300 + i); tok_big.tok_b = fb(300 + i);
            tick();
            if (b_arr_en) en_cnt++;
        end
        tok_big.tok_valid = 1'b0; done = 1'b0;
        n_chk++; if (b_busy !== 1'b1 || b_res_valid !== 1'b0 || tok_big.tok_ready !== 1'b0) begin n_err++; $display("FAIL ign_feed: got busy=%0b rv=%0b rdy=%0b want 1 0 0", b_busy, b_res_valid, tok_big.tok_ready); end
        tick(); tick();
        n_chk++; if (b_res_valid !== 1'b0 || tok_big.tok_ready !== 1'b0 || b_arr_en !== 1'b0) begin n_err++; $display("FAIL ign_drain: got rv=%0b rdy=%0b en=%0b want 0 0 0", b_res_valid, tok_big.tok_ready, b_arr_en); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_chk++; if (b_res_valid !== 1'b1 || b_err !== 1'b0 || b_tile !== 32'd6 || en_cnt !== 4) begin n_err++; $display("FAIL ign_result: got rv=%0b err=%0b tile=%0d en=%0d want 1 0 6 4", b_res_valid, b_err, b_tile, en_cnt); end
        for (int w = 0; w < 20; w++) begin
            tick();
            n_chk++; if (b_res_valid !== 1'b1 || b_err !== 1'b0) begin n_err++; $display("FAIL ign_hold[%0d]: got rv=%0b err=%0b want 1 0", w, b_res_valid, b_err); end
        end
        start = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_chk++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL ign_release: got busy=%0b want 0", b_busy); end
        tick();
        n_chk++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL ign_no_queue: got busy=%0b want 0", b_busy); end
    endtask

    initial begin
        tok_big.tok_valid = 1'b0; tok_big.tok_a = '0; tok_big.tok_b = '0;
        tok_sml.tok_valid = 1'b0; tok_sml.tok_a = '0; tok_sml.tok_b = '0;
        test_reset();
        test_full_tile();
        test_bubbles();
        test_zero_k();
        test_timeout();
        test_reset_mid_feed();
        test_ignored();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
